mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- Memory-access/writeback stage downstream of the execute stage.
- Takes the ALU result, rs2 data and the memory control signals, and runs a multi-cycle req/ack transaction to data memory.
- Aligns and extends load data, then produces the register-file write port.
- Holds `busy` high while a transaction is outstanding, so PC update and fetch stall.

Parameters:
- ACK_TIMEOUT, 256: cycles to wait for `dmem_ack` before aborting the access (range 1–65535).

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: the instruction in execute has a stage-4 action
- alu_result  in  32  execute Result: memory address, or writeback data
- store_data  in  32  rs2 value for stores
- MemOp  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- MemWr  in  1  1 = store
- MemtoReg  in  1  1 = load (writeback from memory)
- RegWr  in  1  register write enable
- rd  in  5  destination register
- dmem_req  out  1  bus request, held until acknowledged
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_wstrb  out  4  byte write strobes
- dmem_ack  in  1  one-cycle completion; `dmem_rdata` is valid in the same cycle
- dmem_rdata  in  32  read word
- wb_en  out  1  register-file write strobe, one cycle
- wb_rd  out  5  write register index
- wb_data  out  32  write data
- busy  out  1  stall: high whenever state != IDLE
- bus_err  out  1  one-cycle pulse on ack timeout
- misalign  out  1  one-cycle pulse on misaligned access (feature only, else 0)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, counter cleared, and every output is 0. `dmem_req` drops immediately, even in the middle of a transaction; any outstanding access is abandoned.
- FSM states: IDLE, ACCESS, WB.
- IDLE:
  - On `start`, latch alu_result, store_data, MemOp, MemWr, MemtoReg, RegWr and rd.
  - If MemWr or MemtoReg is set, go to ACCESS; otherwise go to WB.
  - `start` while busy is ignored, with no latching.
- ACCESS:
  - `dmem_req`=1 starting the cycle after `start`.
  - addr, we, wdata and wstrb stay stable until ack.
  - On `dmem_ack`: a load captures the aligned data and goes to WB; a store goes to IDLE.
  - Timeout counter starts at 0 on entry. If it reaches ACK_TIMEOUT with no ack: pulse `bus_err`, drop req, go to IDLE, no writeback.
  - `dmem_ack` sampled while not in ACCESS is ignored.
- WB:
  - `wb_en` = RegWr && (rd != 0) for exactly one cycle.
  - `wb_rd` = rd.
  - `wb_data` = alu_result for non-memory instructions, or the extended load data for loads.
  - Next state: IDLE.
- Latency:
  - Non-memory instruction: `wb_en` one cycle after `start`.
  - Load: `wb_en` one cycle after `dmem_ack`.
  - Store: `busy` falls one cycle after `dmem_ack`.
- Store lanes:
  - SB: wstrb = 4'b0001 << addr[1:0]; wdata = {4{byte}}.
  - SH: wstrb = addr[1] ? 4'b1100 : 4'b0011; wdata = {2{half}}.
  - SW: wstrb = 4'b1111.
- Load lanes:
  - Byte selected by addr[1:0]; halfword selected by addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
  - Reserved MemOp values are treated as W.
- Back-to-back: `start` is accepted in the cycle after `busy` falls.

Optional Feature:
- MISALIGN_TRAP_EN defined:
  - At `start`, an H/HU access with addr[0]=1, or a W access with addr[1:0]!=0, issues no bus request.
  - `misalign` pulses in the following cycle (state stays IDLE, `busy` stays 0, no writeback).
- MISALIGN_TRAP_EN undefined:
  - `misalign` is tied 0.
  - Low address bits below the access size are ignored (H uses addr[1] only, W uses the full word).

Test Plan:
- Non-memory op: start, MemtoReg=0, RegWr=1, rd=5, alu_result=0x1234 -> next cycle wb_en=1, wb_rd=5, wb_data=0x1234; dmem_req stays 0.
- LB at 0x1003, rdata=0x80FF_FF7F, ack after 3 cycles -> req held 3 cycles; wb_data=0xFFFF_FF80. The same access with LBU -> 0x0000_0080.
- SH at 0x2002, store_data=0xDEAD_BEEF -> dmem_addr=0x2000, wstrb=4'b1100, wdata=0xBEEF_BEEF, we=1; no wb_en; busy falls the cycle after ack.
- ACK_TIMEOUT=4, no ack -> bus_err pulses once after 4 req cycles; req drops; wb_en never asserts; the next start is accepted.
- Load with rd=0 -> WB state entered, wb_en=0. A start during ACCESS is ignored (latched address unchanged).
- With MISALIGN_TRAP_EN, LW at 0x3001 -> misalign=1 one cycle, dmem_req=0. Assert rst mid-ACCESS -> dmem_req=0 and busy=0 immediately.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the memory-access stage and data memory.
// The unit drives the request side (master); the memory returns ack and read data (slave).
interface mem_access_unit_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_wstrb;
    logic        dmem_ack;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        input  dmem_ack, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_wstrb,
        output dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-access / writeback stage: runs a req/ack data-memory transaction, aligns loads, drives the RF write port.
// Optional misaligned-access trap is enabled by defining MISALIGN_TRAP_EN.
module mem_access_unit #(
    parameter int unsigned ACK_TIMEOUT = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [2:0]  MemOp,
    input  logic        MemWr,
    input  logic        MemtoReg,
    input  logic        RegWr,
    input  logic [4:0]  rd,
    mem_access_unit_if.master dmem,
    output logic        wb_en,
    output logic [4:0]  wb_rd,
    output logic [31:0] wb_data,
    output logic        busy,
    output logic        bus_err,
    output logic        misalign
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] ACCESS = 2'd1;
    localparam logic [1:0] WB     = 2'd2;

    localparam logic [15:0] CNT_LAST = 16'(ACK_TIMEOUT - 1);

    logic [1:0]  state;
    logic [31:0] addr_q;
    logic [31:0] sdata_q;
    logic [2:0]  op_q;
    logic        wr_q;
    logic        ld_q;
    logic        regwr_q;
    logic [4:0]  rd_q;
    logic [31:0] load_q;
    logic [15:0] cnt;
    logic        bus_err_q;

    logic        start_misaligned;
    logic        is_byte;
    logic        is_half;
    logic [3:0]  lane_strb;
    logic [31:0] lane_wdata;
    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;
    logic [31:0] load_ext;
    logic        in_access;
    logic        in_wb;

    // Access size comes from funct3[1:0]; 011/110/111 fall through to word.
    assign is_byte = (op_q[1:0] == 2'b00);
    assign is_half = (op_q[1:0] == 2'b01);

`ifdef MISALIGN_TRAP_EN
    logic misalign_q;

    assign start_misaligned = (MemWr || MemtoReg) &&
                              (((MemOp[1:0] == 2'b01) && alu_result[0]) ||
                               (MemOp[1] && (alu_result[1:0] != 2'b00)));
    assign misalign = misalign_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= (state == IDLE) && start && start_misaligned;
        end
    end
`else
    assign start_misaligned = 1'b0;
    assign misalign         = 1'b0;
`endif

    always_comb begin
        lane_strb  = 4'b1111;
        lane_wdata = sdata_q;
        if (is_byte) begin
            lane_strb  = 4'b0001 << addr_q[1:0];
            lane_wdata = {4{sdata_q[7:0]}};
        end else if (is_half) begin
            lane_strb  = addr_q[1] ? 4'b1100 : 4'b0011;
            lane_wdata = {2{sdata_q[15:0]}};
        end
    end

    // Load lane select: the halfword ignores addr[0], so misaligned halves read the aligned pair.
    assign byte_shifted = dmem.dmem_rdata >> {addr_q[1:0], 3'b000};
    assign half_shifted = dmem.dmem_rdata >> {addr_q[1], 4'b0000};

    always_comb begin
        load_ext = dmem.dmem_rdata;
        if (is_byte) begin
            load_ext = op_q[2] ? {24'b0, byte_shifted[7:0]}
                               : {{24{byte_shifted[7]}}, byte_shifted[7:0]};
        end else if (is_half) begin
            load_ext = op_q[2] ? {16'b0, half_shifted[15:0]}
                               : {{16{half_shifted[15]}}, half_shifted[15:0]};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            sdata_q   <= '0;
            op_q      <= '0;
            wr_q      <= 1'b0;
            ld_q      <= 1'b0;
            regwr_q   <= 1'b0;
            rd_q      <= '0;
            load_q    <= '0;
            cnt       <= '0;
            bus_err_q <= 1'b0;
        end else begin
            bus_err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !start_misaligned) begin
                        addr_q  <= alu_result;
                        sdata_q <= store_data;
                        op_q    <= MemOp;
                        wr_q    <= MemWr;
                        ld_q    <= MemtoReg;
                        regwr_q <= RegWr;
                        rd_q    <= rd;
                        cnt     <= '0;
                        state   <= (MemWr || MemtoReg) ? ACCESS : WB;
                    end
                end
                ACCESS: begin
                    if (dmem.dmem_ack) begin
                        if (wr_q) begin
                            state <= IDLE;
                        end else begin
                            load_q <= load_ext;
                            state  <= WB;
                        end
                    end else if (cnt == CNT_LAST) begin
                        bus_err_q <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign in_access = (state == ACCESS);
    assign in_wb     = (state == WB);

    assign dmem.dmem_req   = in_access;
    assign dmem.dmem_we    = in_access && wr_q;
    assign dmem.dmem_addr  = in_access ? {addr_q[31:2], 2'b00} : 32'd0;
    assign dmem.dmem_wdata = (in_access && wr_q) ? lane_wdata : 32'd0;
    assign dmem.dmem_wstrb = (in_access && wr_q) ? lane_strb : 4'd0;

    assign wb_en   = in_wb && regwr_q && (rd_q != 5'd0);
    assign wb_rd   = in_wb ? rd_q : 5'd0;
    assign wb_data = in_wb ? (ld_q ? load_q : addr_q) : 32'd0;

    assign busy    = (state != IDLE);
    assign bus_err = bus_err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed cases plus randomized transactions
// checked against a transaction-level reference model.
module tb_mem_access_unit;

   localparam int unsigned TIMEOUT = 4;
`ifdef MISALIGN_TRAP_EN
   localparam bit TRAP = 1'b1;
`else
   localparam bit TRAP = 1'b0;
`endif

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [31:0] aluResult = '0;
   logic [31:0] storeData = '0;
   logic [2:0]  memOp = '0;
   logic        memWr = 1'b0;
   logic        memToReg = 1'b0;
   logic        regWr = 1'b0;
   logic [4:0]  rdIdx = '0;
   logic        wbEn;
   logic [4:0]  wbRd;
   logic [31:0] wbData;
   logic        busy;
   logic        busErr;
   logic        misalign;

   int testsRun = 0;
   int testsFailed = 0;

   mem_access_unit_if dmem ();

   mem_access_unit #(.ACK_TIMEOUT(TIMEOUT)) dut (
      .clk        (clock),
      .rst        (reset),
      .start      (start),
      .alu_result (aluResult),
      .store_data (storeData),
      .MemOp      (memOp),
      .MemWr      (memWr),
      .MemtoReg   (memToReg),
      .RegWr      (regWr),
      .rd         (rdIdx),
      .dmem       (dmem),
      .wb_en      (wbEn),
      .wb_rd      (wbRd),
      .wb_data    (wbData),
      .busy       (busy),
      .bus_err    (busErr),
      .misalign   (misalign)
   );

   always #5 clock = ~clock;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      testsRun++;
      if (observed !== expected) begin
         testsFailed++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
      end
   endtask

   // Reference model: access size classes from funct3, reserved codes behave as word.
   function automatic int sizeOf(input logic [2:0] op);
      if (op == 3'd0 || op == 3'd4) return 1;
      if (op == 3'd1 || op == 3'd5) return 2;
      return 4;
   endfunction

   function automatic logic [31:0] expLoad(input logic [31:0] rdata, input logic [31:0] a, input logic [2:0] op);
      logic [31:0] v;
      if (sizeOf(op) == 1) begin
         v = (rdata >> (8 * int'(a[1:0]))) & 32'hFF;
         if (op == 3'd0 && v >= 32'h80) v = v + 32'hFFFFFF00;
      end else if (sizeOf(op) == 2) begin
         v = (rdata >> (16 * int'(a[1]))) & 32'hFFFF;
         if (op == 3'd1 && v >= 32'h8000) v = v + 32'hFFFF0000;
      end else begin
         v = rdata;
      end
      return v;
   endfunction

   function automatic logic [31:0] expStrb(input logic [31:0] a, input logic [2:0] op);
      if (sizeOf(op) == 1) return 32'(1 << int'(a[1:0]));
      if (sizeOf(op) == 2) return 32'(3 << (2 * int'(a[1])));
      return 32'hF;
   endfunction

   function automatic logic [31:0] expWdata(input logic [31:0] sd, input logic [2:0] op);
      if (sizeOf(op) == 1) return (sd & 32'hFF) * 32'h01010101;
      if (sizeOf(op) == 2) return (sd & 32'hFFFF) * 32'h00010001;
      return sd;
   endfunction

   function automatic bit isMisaligned(input logic [31:0] a, input logic [2:0] op);
      return (a % sizeOf(op)) != 0;
   endfunction

   // One complete instruction through the stage. reqCycles = request cycles up to and
   // including the ack cycle, or 0 for a memory that never answers.
   task automatic applyStimulus(input logic [31:0] a, input logic [31:0] sd, input logic [2:0] op,
                                input logic wr, input logic ld, input logic rw, input logic [4:0] r,
                                input int reqCycles, input logic [31:0] rdata, input bit stray);
      bit mem;
      bit mis;
      bit expWb;
      mem = wr || ld;
      mis = TRAP && mem && isMisaligned(a, op);
      expWb = rw && (r != 5'd0);
      @(negedge clock);
      aluResult = a; storeData = sd; memOp = op;
      memWr = wr; memToReg = ld; regWr = rw; rdIdx = r;
      start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("misalign", 32'(misalign), 32'(mis));
      if (mis) begin
         checkOutput("trap_req", 32'(dmem.dmem_req), 32'd0);
         checkOutput("trap_busy", 32'(busy), 32'd0);
         checkOutput("trap_wb_en", 32'(wbEn), 32'd0);
         @(negedge clock);
         checkOutput("misalign_end", 32'(misalign), 32'd0);
         return;
      end
      if (!mem) begin
         checkOutput("alu_wb_en", 32'(wbEn), 32'(expWb));
         checkOutput("alu_wb_rd", 32'(wbRd), 32'(r));
         checkOutput("alu_wb_data", wbData, a);
         checkOutput("alu_req", 32'(dmem.dmem_req), 32'd0);
         checkOutput("alu_busy", 32'(busy), 32'd1);
         @(negedge clock);
         checkOutput("alu_busy_end", 32'(busy), 32'd0);
         checkOutput("alu_wb_en_end", 32'(wbEn), 32'd0);
         return;
      end
      for (int k = 1; k <= int'(TIMEOUT); k++) begin
         checkOutput("req", 32'(dmem.dmem_req), 32'd1);
         checkOutput("we", 32'(dmem.dmem_we), 32'(wr));
         checkOutput("addr", dmem.dmem_addr, a & 32'hFFFFFFFC);
         checkOutput("acc_busy", 32'(busy), 32'd1);
         if (wr) begin
            checkOutput("wstrb", 32'(dmem.dmem_wstrb), expStrb(a, op));
            checkOutput("wdata", dmem.dmem_wdata, expWdata(sd, op));
         end
         if (stray && k == 1) begin
            start = 1'b1;
            aluResult = ~a;
         end
         if (k == reqCycles) begin
            dmem.dmem_ack = 1'b1;
            dmem.dmem_rdata = rdata;
         end
         @(negedge clock);
         dmem.dmem_ack = 1'b0;
         dmem.dmem_rdata = $urandom;
         start = 1'b0;
         if (k == reqCycles) break;
      end
      if (reqCycles == 0) begin
         checkOutput("bus_err", 32'(busErr), 32'd1);
         checkOutput("to_req", 32'(dmem.dmem_req), 32'd0);
         checkOutput("to_busy", 32'(busy), 32'd0);
         checkOutput("to_wb_en", 32'(wbEn), 32'd0);
         @(negedge clock);
         checkOutput("bus_err_end", 32'(busErr), 32'd0);
      end else if (wr) begin
         checkOutput("st_busy", 32'(busy), 32'd0);
         checkOutput("st_wb_en", 32'(wbEn), 32'd0);
         checkOutput("st_bus_err", 32'(busErr), 32'd0);
      end else begin
         checkOutput("ld_wb_en", 32'(wbEn), 32'(expWb));
         checkOutput("ld_wb_rd", 32'(wbRd), 32'(r));
         checkOutput("ld_wb_data", wbData, expLoad(rdata, a, op));
         checkOutput("ld_req", 32'(dmem.dmem_req), 32'd0);
         @(negedge clock);
         checkOutput("ld_busy_end", 32'(busy), 32'd0);
         checkOutput("ld_wb_en_end", 32'(wbEn), 32'd0);
      end
   endtask

   // Reset asserted in the middle of a load must abandon it at once.
   task automatic applyMidReset();
      @(negedge clock);
      aluResult = 32'h0000_4000; memOp = 3'd2; memWr = 1'b0; memToReg = 1'b1;
      regWr = 1'b1; rdIdx = 5'd7; start = 1'b1;
      @(negedge clock);
      start = 1'b0;
      checkOutput("rst_pre_req", 32'(dmem.dmem_req), 32'd1);
      #2 reset = 1'b0;
      #1;
      checkOutput("rst_req", 32'(dmem.dmem_req), 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_addr", dmem.dmem_addr, 32'd0);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      checkOutput("rst_after_busy", 32'(busy), 32'd0);
      checkOutput("rst_after_wb_en", 32'(wbEn), 32'd0);
   endtask

   initial begin
      logic [2:0] op;
      int kind;
      int reqs;
      dmem.dmem_ack = 1'b0;
      dmem.dmem_rdata = '0;
      repeat (2) @(negedge clock);
      checkOutput("reset_req", 32'(dmem.dmem_req), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_wb_en", 32'(wbEn), 32'd0);
      checkOutput("reset_wb_data", wbData, 32'd0);
      checkOutput("reset_bus_err", 32'(busErr), 32'd0);
      checkOutput("reset_misalign", 32'(misalign), 32'd0);
      reset = 1'b1;

      applyStimulus(32'h0000_1234, 32'h0, 3'd2, 1'b0, 1'b0, 1'b1, 5'd5, 1, 32'h0, 1'b0);
      applyStimulus(32'h0000_1003, 32'h0, 3'd0, 1'b0, 1'b1, 1'b1, 5'd9, 3, 32'h80FF_FF7F, 1'b0);
      applyStimulus(32'h0000_1003, 32'h0, 3'd4, 1'b0, 1'b1, 1'b1, 5'd9, 3, 32'h80FF_FF7F, 1'b0);
      applyStimulus(32'h0000_2002, 32'hDEAD_BEEF, 3'd1, 1'b1, 1'b0, 1'b0, 5'd0, 2, 32'h0, 1'b0);
      applyStimulus(32'h0000_5000, 32'h0, 3'd2, 1'b0, 1'b1, 1'b1, 5'd3, 0, 32'h0, 1'b0);
      applyStimulus(32'h0000_6004, 32'h0, 3'd2, 1'b0, 1'b1, 1'b1, 5'd0, 2, 32'h1357_9BDF, 1'b1);
      applyStimulus(32'h0000_3001, 32'h0, 3'd2, 1'b0, 1'b1, 1'b1, 5'd4, 1, 32'hCAFE_F00D, 1'b0);
      applyMidReset();

      for (int i = 0; i < 120; i++) begin
         kind = int'($urandom_range(0, 2));
         op = 3'($urandom_range(0, 7));
         reqs = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, TIMEOUT));
         applyStimulus($urandom, $urandom, op, kind == 2, kind == 1, 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 31)), reqs, $urandom, $urandom_range(0, 3) == 0);
      end

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
